tlb_ctrl: RTL and testbench

- Executes the CP0 TLB-management instructions TLBR, TLBWI, TLBWR and TLBP against a 32-entry joint TLB.
- Acts as the responder to the CP0 register file:
  - consumes the Index, EntryHi, EntryLo0/1, PageMask and Wired register images;
  - returns write-back values for those registers;
  - owns the Random register counter.
- Sits beside cp0 in the memory stage.
- Translation lookup ports are out of scope; a later block adds them.

---
 rtl/cp0_pkg.sv | 79 +++++++
 rtl/tlb_random.sv | 29 ++
 rtl/tlb_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_tlb_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// CP0 register images and joint-TLB types shared by the TLB management logic.
package cp0_pkg;
    localparam int TLB_INDEX   = 5;
    localparam int PABITS      = 36;
    localparam int TLB_ENTRIES = 2 ** TLB_INDEX;
    localparam int PFN_W       = PABITS - 12;

    typedef enum logic [1:0] {
        TLB_OP_TLBR  = 2'd0,
        TLB_OP_TLBWI = 2'd1,
        TLB_OP_TLBWR = 2'd2,
        TLB_OP_TLBP  = 2'd3
    } tlb_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } tlb_state_t;

    typedef struct packed {
        logic                   p;
        logic [30-TLB_INDEX:0]  zero;
        logic [TLB_INDEX-1:0]   index;
    } cp0_index_t;

    typedef struct packed {
        logic [31-TLB_INDEX:0]  zero;
        logic [TLB_INDEX-1:0]   random;
    } cp0_random_t;

    typedef struct packed {
        logic [31-TLB_INDEX:0]  zero;
        logic [TLB_INDEX-1:0]   wired;
    } cp0_wired_t;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [4:0]  zero;
        logic [7:0]  asid;
    } cp0_entryhi_t;

    typedef struct packed {
        logic [25-PFN_W:0] zero;
        logic [PFN_W-1:0]  pfn;
        logic [2:0]        c;
        logic              d;
        logic              v;
        logic              g;
    } cp0_entrylo_t;

    typedef struct packed {
        logic [2:0]  zero_hi;
        logic [15:0] mask;
        logic [12:0] zero_lo;
    } cp0_pagemask_t;

    typedef struct packed {
        logic [18:0]      vpn2;
        logic [7:0]       asid;
        logic [15:0]      mask;
        logic             g;
        logic [PFN_W-1:0] pfn0;
        logic [2:0]       c0;
        logic             d0;
        logic             v0;
        logic [PFN_W-1:0] pfn1;
        logic [2:0]       c1;
        logic             d1;
        logic             v1;
    } tlb_entry_t;

    // Masked bits of the page mask widen the page, so they drop out of the VPN2 compare.
    function automatic logic tlb_match(tlb_entry_t e, logic [18:0] vpn2, logic [7:0] asid);
        logic [18:0] diff;
        diff = (e.vpn2 ^ vpn2) & ~{3'b000, e.mask};
        return (diff == '0) && (e.g || (e.asid == asid));
    endfunction
endpackage

// File: rtl/tlb_random.sv
// CP0 Random counter: counts down each cycle, reloading to the top entry at or below Wired.
module tlb_random
    import cp0_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [TLB_INDEX-1:0] wired,
    input  logic                 wired_we,
    output logic [TLB_INDEX-1:0] count
);
    localparam logic [TLB_INDEX-1:0] TOP = '1;

    logic [TLB_INDEX-1:0] count_next;

    always_comb begin
        count_next = count - TLB_INDEX'(1);
        if (wired_we || (count <= wired) || (count == '0)) begin
            count_next = TOP;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= TOP;
        end else begin
            count <= count_next;
        end
    end
endmodule

// File: rtl/tlb_ctrl.sv
// CP0 TLB management: executes TLBR/TLBWI/TLBWR/TLBP against the 32-entry joint TLB.
//   state   | meaning
//   IDLE    | op_ready high, waiting for a request
//   EXEC    | entry write, entry read or parallel probe
//   DONE    | done pulse, write-back flags valid
module tlb_ctrl
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  tlb_op_t     op,
    output logic        op_ready,
    input  logic [31:0] index_i,
    input  logic [31:0] entryhi_i,
    input  logic [31:0] entrylo0_i,
    input  logic [31:0] entrylo1_i,
    input  logic [31:0] pagemask_i,
    input  logic [31:0] wired_i,
    input  logic        wired_we,
    output logic        done,
    output logic        wb_tlbr,
    output logic        wb_tlbp,
    output logic [31:0] wb_entryhi,
    output logic [31:0] wb_entrylo0,
    output logic [31:0] wb_entrylo1,
    output logic [31:0] wb_pagemask,
    output logic [31:0] wb_index,
    output logic [31:0] random_o
);
    cp0_index_t    index_img;
    cp0_entryhi_t  hi_img;
    cp0_entrylo_t  lo0_img;
    cp0_entrylo_t  lo1_img;
    cp0_pagemask_t pm_img;
    cp0_wired_t    wired_img;
    cp0_random_t   random_img;
    logic          unused_bits;

    assign index_img = index_i;
    assign hi_img    = entryhi_i;
    assign lo0_img   = entrylo0_i;
    assign lo1_img   = entrylo1_i;
    assign pm_img    = pagemask_i;
    assign wired_img = wired_i;
    assign unused_bits = ^{index_img.p, index_img.zero, hi_img.zero, lo0_img.zero,
                           lo1_img.zero, pm_img.zero_hi, pm_img.zero_lo, wired_img.zero};

    tlb_state_t           state;
    tlb_state_t           state_next;
    tlb_op_t              op_q;
    logic [TLB_INDEX-1:0] target_q;
    tlb_entry_t           req;
    tlb_entry_t           req_q;
    tlb_entry_t           entries [TLB_ENTRIES];
    tlb_entry_t           rd_entry;
    logic [TLB_INDEX-1:0] random_idx;
    logic                 accept;
    logic                 probe_hit;
    logic [TLB_INDEX-1:0] probe_idx;
    cp0_index_t           probe_img;
    cp0_entryhi_t         rd_hi;
    cp0_entrylo_t         rd_lo0;
    cp0_entrylo_t         rd_lo1;
    cp0_pagemask_t        rd_pm;

    tlb_random u_random (
        .clk      (clk),
        .resetn   (resetn),
        .wired    (wired_img.wired),
        .wired_we (wired_we),
        .count    (random_idx)
    );

    always_comb begin
        random_img        = '0;
        random_img.random = random_idx;
    end
    assign random_o = random_img;

    always_comb begin
        state_next = state;
        op_ready   = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) state_next = ST_EXEC;
            end
            ST_EXEC: state_next = ST_DONE;
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign accept  = op_valid && op_ready;
    assign wb_tlbr = done && (op_q == TLB_OP_TLBR);
    assign wb_tlbp = done && (op_q == TLB_OP_TLBP);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The request is reduced to entry form at acceptance so later CP0 updates cannot leak in.
    always_comb begin
        req      = '0;
        req.vpn2 = hi_img.vpn2;
        req.asid = hi_img.asid;
        req.mask = pm_img.mask;
        req.g    = lo0_img.g & lo1_img.g;
        req.pfn0 = lo0_img.pfn;
        req.c0   = lo0_img.c;
        req.d0   = lo0_img.d;
        req.v0   = lo0_img.v;
        req.pfn1 = lo1_img.pfn;
        req.c1   = lo1_img.c;
        req.d1   = lo1_img.d;
        req.v1   = lo1_img.v;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q     <= TLB_OP_TLBR;
            target_q <= '0;
            req_q    <= '0;
        end else if (accept) begin
            op_q     <= op;
            target_q <= (op == TLB_OP_TLBWR) ? random_idx : index_img.index;
            req_q    <= req;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < TLB_ENTRIES; i++) entries[i] <= '0;
        end else if ((state == ST_EXEC) && ((op_q == TLB_OP_TLBWI) || (op_q == TLB_OP_TLBWR))) begin
            entries[target_q] <= req_q;
        end
    end

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        probe_hit = 1'b0;
        probe_idx = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (tlb_match(entries[i], req_q.vpn2, req_q.asid)) begin
                probe_hit = 1'b1;
                probe_idx = TLB_INDEX'(i);
            end
        end
        probe_img       = '0;
        probe_img.p     = !probe_hit;
        probe_img.index = probe_idx;
    end

    assign rd_entry = entries[target_q];

    always_comb begin
        rd_hi      = '0;
        rd_hi.vpn2 = rd_entry.vpn2;
        rd_hi.asid = rd_entry.asid;
        rd_lo0     = '0;
        rd_lo0.pfn = rd_entry.pfn0;
        rd_lo0.c   = rd_entry.c0;
        rd_lo0.d   = rd_entry.d0;
        rd_lo0.v   = rd_entry.v0;
        rd_lo0.g   = rd_entry.g;
        rd_lo1     = '0;
        rd_lo1.pfn = rd_entry.pfn1;
        rd_lo1.c   = rd_entry.c1;
        rd_lo1.d   = rd_entry.d1;
        rd_lo1.v   = rd_entry.v1;
        rd_lo1.g   = rd_entry.g;
        rd_pm      = '0;
        rd_pm.mask = rd_entry.mask;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wb_entryhi  <= '0;
            wb_entrylo0 <= '0;
            wb_entrylo1 <= '0;
            wb_pagemask <= '0;
            wb_index    <= '0;
        end else if (state == ST_EXEC) begin
            if (op_q == TLB_OP_TLBR) begin
                wb_entryhi  <= rd_hi;
                wb_entrylo0 <= rd_lo0;
                wb_entrylo1 <= rd_lo1;
                wb_pagemask <= rd_pm;
            end
            if (op_q == TLB_OP_TLBP) begin
                wb_index <= probe_img;
            end
        end
    end
endmodule

// File: tb/tb_tlb_ctrl.sv
// Bench for tlb_ctrl: directed vector table, hand-written corner sequences, random ops vs a model.
module tb_tlb_ctrl;
    import cp0_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        op_valid = 1'b0;
    tlb_op_t     op_sel = TLB_OP_TLBR;
    logic        op_ready;
    logic [31:0] index_i = '0, entryhi_i = '0, entrylo0_i = '0, entrylo1_i = '0;
    logic [31:0] pagemask_i = '0, wired_i = '0;
    logic        wired_we = 1'b0;
    logic        done, wb_tlbr, wb_tlbp;
    logic [31:0] wb_entryhi, wb_entrylo0, wb_entrylo1, wb_pagemask, wb_index, random_o;

    tlb_ctrl dut (
        .clk(clk), .resetn(resetn), .op_valid(op_valid), .op(op_sel), .op_ready(op_ready),
        .index_i(index_i), .entryhi_i(entryhi_i), .entrylo0_i(entrylo0_i),
        .entrylo1_i(entrylo1_i), .pagemask_i(pagemask_i), .wired_i(wired_i),
        .wired_we(wired_we), .done(done), .wb_tlbr(wb_tlbr), .wb_tlbp(wb_tlbp),
        .wb_entryhi(wb_entryhi), .wb_entrylo0(wb_entrylo0), .wb_entrylo1(wb_entrylo1),
        .wb_pagemask(wb_pagemask), .wb_index(wb_index), .random_o(random_o)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    // Reference state: stored register images with zero fields already stripped.
    int          rnd_m;
    logic [31:0] m_hi [32];
    logic [31:0] m_lo0 [32];
    logic [31:0] m_lo1 [32];
    logic [31:0] m_pm [32];
    logic        m_g [32];
    logic        cap_tlbr, cap_tlbp;

    function automatic int rnd_next(int r, int w, logic we);
        if (we || r <= w || r == 0) return 31;
        return r - 1;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) rnd_m <= 31;
        else         rnd_m <= rnd_next(rnd_m, int'(wired_i[4:0]), wired_we);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (resetn) chk("random_o", random_o, rnd_m);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_hi[i] = '0; m_lo0[i] = '0; m_lo1[i] = '0; m_pm[i] = '0; m_g[i] = 1'b0;
        end
    endtask

    task automatic model_write(input int t, input logic [31:0] hi, l0, l1, pm);
        m_hi[t]  = hi & 32'hFFFF_E0FF;
        m_lo0[t] = l0 & 32'h3FFF_FFFE;
        m_lo1[t] = l1 & 32'h3FFF_FFFE;
        m_pm[t]  = pm & 32'h1FFF_E000;
        m_g[t]   = l0[0] & l1[0];
    endtask

    function automatic logic [31:0] model_probe(input logic [31:0] hi);
        for (int i = 0; i < 32; i++) begin
            logic [18:0] d;
            d = (m_hi[i][31:13] ^ hi[31:13]) & ~{3'b000, m_pm[i][28:13]};
            if (d == 19'd0 && (m_g[i] || m_hi[i][7:0] == hi[7:0])) return 32'(i);
        end
        return 32'h8000_0000;
    endfunction

    task automatic check_read(input string tag, input int t);
        chk({tag, "_tlbr"}, 32'(cap_tlbr), 1);
        chk({tag, "_hi"},  wb_entryhi,  m_hi[t]);
        chk({tag, "_lo0"}, wb_entrylo0, m_lo0[t] | 32'(m_g[t]));
        chk({tag, "_lo1"}, wb_entrylo1, m_lo1[t] | 32'(m_g[t]));
        chk({tag, "_pm"},  wb_pagemask, m_pm[t]);
    endtask

    // Drives one request from a negedge; returns at the negedge after done has dropped.
    task automatic do_op(input tlb_op_t o, input logic [31:0] idx, hi, l0, l1, pm);
        int n;
        int tgt;
        n = 0;
        while (!op_ready && n < 20) begin tick(); n++; end
        chk("op_ready_wait", 32'(op_ready), 1);
        op_sel = o; index_i = idx; entryhi_i = hi; entrylo0_i = l0; entrylo1_i = l1;
        pagemask_i = pm; op_valid = 1'b1;
        tgt = (o == TLB_OP_TLBWR) ? rnd_m : int'(idx[4:0]);
        tick();
        op_valid = 1'b0;
        op_sel = tlb_op_t'($urandom_range(0, 3));
        index_i = $urandom; entryhi_i = $urandom; entrylo0_i = $urandom;
        entrylo1_i = $urandom; pagemask_i = $urandom;
        chk("exec_done_low", 32'(done), 0);
        chk("exec_busy", 32'(op_ready), 0);
        tick();
        chk("done_latency", 32'(done), 1);
        cap_tlbr = wb_tlbr;
        cap_tlbp = wb_tlbp;
        if (o == TLB_OP_TLBWI || o == TLB_OP_TLBWR) model_write(tgt, hi, l0, l1, pm);
        tick();
        chk("done_pulse", 32'(done), 0);
    endtask

    task automatic wait_rnd(input int v);
        int n = 0;
        while (random_o != 32'(v) && n < 80) begin tick(); n++; end
        chk("wait_random", random_o, 32'(v));
    endtask

    typedef struct {
        tlb_op_t     op;
        logic [31:0] idx, hi, lo0, lo1, pm;
        logic [31:0] e_hi, e_lo0, e_lo1, e_pm, e_index;
    } vec_t;

    vec_t        vecs [13];
    logic [18:0] vpn_pool [4];
    logic [7:0]  asid_pool [2];
    logic [31:0] pm_pool [4];

    initial begin
        int n_done;
        vecs[0]  = '{TLB_OP_TLBWI, 32'h25, 32'h2468BF3A, 32'hC002AF1F, 32'h000048D3, 32'h0, 0, 0, 0, 0, 0};
        vecs[1]  = '{TLB_OP_TLBR,  32'h05, 0, 0, 0, 0, 32'h2468A03A, 32'h0002AF1F, 32'h000048D3, 32'h0, 0};
        vecs[2]  = '{TLB_OP_TLBP,  32'h0, 32'h2468A007, 0, 0, 0, 0, 0, 0, 0, 32'h00000005};
        vecs[3]  = '{TLB_OP_TLBWI, 32'h05, 32'h2468A03A, 32'h0002AF1E, 32'h000048D3, 32'h0, 0, 0, 0, 0, 0};
        vecs[4]  = '{TLB_OP_TLBR,  32'h05, 0, 0, 0, 0, 32'h2468A03A, 32'h0002AF1E, 32'h000048D2, 32'h0, 0};
        vecs[5]  = '{TLB_OP_TLBP,  32'h0, 32'h2468A007, 0, 0, 0, 0, 0, 0, 0, 32'h80000000};
        vecs[6]  = '{TLB_OP_TLBWI, 32'h09, 32'h00200011, 32'h00000042, 32'h0, 32'hE001FFFF, 0, 0, 0, 0, 0};
        vecs[7]  = '{TLB_OP_TLBWI, 32'h03, 32'h0020A011, 32'h00000082, 32'h0, 32'h0001E000, 0, 0, 0, 0, 0};
        vecs[8]  = '{TLB_OP_TLBP,  32'h0, 32'h00214011, 0, 0, 0, 0, 0, 0, 0, 32'h00000003};
        vecs[9]  = '{TLB_OP_TLBR,  32'h03, 0, 0, 0, 0, 32'h0020A011, 32'h00000082, 32'h0, 32'h0001E000, 0};
        vecs[10] = '{TLB_OP_TLBR,  32'h09, 0, 0, 0, 0, 32'h00200011, 32'h00000042, 32'h0, 32'h0001E000, 0};
        vecs[11] = '{TLB_OP_TLBR,  32'h00, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0};
        vecs[12] = '{TLB_OP_TLBP,  32'h0, 32'h00214022, 0, 0, 0, 0, 0, 0, 0, 32'h80000000};
        vpn_pool  = '{19'h12345, 19'h00100, 19'h00105, 19'h7FFFF};
        asid_pool = '{8'h11, 8'h3A};
        pm_pool   = '{32'h0, 32'h0001E000, 32'h00006000, 32'h1FFFE000};
        model_clear();

        repeat (3) @(negedge clk);
        resetn = 1'b1;
        chk("rst_random", random_o, 31);
        chk("rst_ready", 32'(op_ready), 1);
        chk("rst_done", 32'(done), 0);
        chk("rst_flags", {30'b0, wb_tlbr, wb_tlbp}, 0);
        chk("rst_wb_hi", wb_entryhi | wb_entrylo0 | wb_entrylo1 | wb_pagemask | wb_index, 0);
        tick(); chk("idle_rnd1", random_o, 30);
        tick(); chk("idle_rnd2", random_o, 29);
        tick(); chk("idle_rnd3", random_o, 28);

        for (int v = 0; v < 13; v++) begin
            do_op(vecs[v].op, vecs[v].idx, vecs[v].hi, vecs[v].lo0, vecs[v].lo1, vecs[v].pm);
            if (vecs[v].op == TLB_OP_TLBR) begin
                chk("vec_tlbr", {30'b0, cap_tlbr, cap_tlbp}, 2);
                chk("vec_hi",  wb_entryhi,  vecs[v].e_hi);
                chk("vec_lo0", wb_entrylo0, vecs[v].e_lo0);
                chk("vec_lo1", wb_entrylo1, vecs[v].e_lo1);
                chk("vec_pm",  wb_pagemask, vecs[v].e_pm);
            end else if (vecs[v].op == TLB_OP_TLBP) begin
                chk("vec_tlbp", {30'b0, cap_tlbr, cap_tlbp}, 1);
                chk("vec_index", wb_index, vecs[v].e_index);
            end else begin
                chk("vec_write_flags", {30'b0, cap_tlbr, cap_tlbp}, 0);
            end
        end

        wired_i = 32'd4;
        wait_rnd(6);
        tick(); chk("wired_seq5", random_o, 5);
        tick(); chk("wired_seq4", random_o, 4);
        tick(); chk("wired_wrap", random_o, 31);
        wired_i = 32'd0;

        wait_rnd(20);
        wired_we = 1'b1;
        tick(); chk("wired_we_reload", random_o, 31);
        wired_we = 1'b0;

        wait_rnd(17);
        op_sel = TLB_OP_TLBWR; index_i = 32'h2; entryhi_i = 32'h0ABCC055;
        entrylo0_i = 32'h00123457; entrylo1_i = 32'h00000ABD; pagemask_i = 32'h00006000;
        op_valid = 1'b1;
        tick();
        chk("hold_exec_done", 32'(done), 0);
        chk("hold_exec_ready", 32'(op_ready), 0);
        tick();
        chk("hold_done", 32'(done), 1);
        op_valid = 1'b0;
        model_write(17, 32'h0ABCC055, 32'h00123457, 32'h00000ABD, 32'h00006000);
        n_done = 0;
        repeat (4) begin tick(); if (done) n_done++; end
        chk("hold_no_second_done", 32'(n_done), 0);
        do_op(TLB_OP_TLBR, 32'd17, 0, 0, 0, 0);
        chk("tlbwr_hi",  wb_entryhi,  32'h0ABCC055);
        chk("tlbwr_lo0", wb_entrylo0, 32'h00123457);
        chk("tlbwr_lo1", wb_entrylo1, 32'h00000ABD);
        chk("tlbwr_pm",  wb_pagemask, 32'h00006000);

        for (int k = 0; k < 200; k++) begin
            tlb_op_t     o;
            logic [31:0] idx, hi, l0, l1, pm;
            if ($urandom_range(0, 9) == 0) wired_i = $urandom_range(0, 12);
            if ($urandom_range(0, 7) == 0) begin wired_we = 1'b1; tick(); wired_we = 1'b0; end
            o  = tlb_op_t'($urandom_range(0, 3));
            idx = $urandom;
            hi = {vpn_pool[$urandom_range(0, 3)], 5'($urandom), asid_pool[$urandom_range(0, 1)]};
            l0 = $urandom;
            l1 = $urandom;
            pm = pm_pool[$urandom_range(0, 3)] | ($urandom & 32'hE000_1FFF);
            do_op(o, idx, hi, l0, l1, pm);
            if (o == TLB_OP_TLBR) begin
                check_read("rand_read", int'(idx[4:0]));
            end else if (o == TLB_OP_TLBP) begin
                chk("rand_tlbp", 32'(cap_tlbp), 1);
                chk("rand_probe", wb_index, model_probe(hi));
            end else begin
                chk("rand_write_flags", {30'b0, cap_tlbr, cap_tlbp}, 0);
            end
        end
        wired_i = 32'd0;

        do_op(TLB_OP_TLBWI, 32'd5, 32'h2468A03A, 32'h0002AF1F, 32'h000048D3, 32'h0);
        op_sel = TLB_OP_TLBWI; index_i = 32'd7; entryhi_i = 32'h0ABCC055;
        entrylo0_i = 32'h00123457; entrylo1_i = 32'h00000ABD; pagemask_i = 32'h0;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        chk("rst_mid_exec", 32'(done), 0);
        resetn = 1'b0;
        model_clear();
        tick(); chk("rst_mid_no_done", 32'(done), 0);
        tick();
        resetn = 1'b1;
        chk("rst_mid_ready", 32'(op_ready), 1);
        chk("rst_mid_random", random_o, 31);
        chk("rst_mid_wb", wb_entryhi | wb_entrylo0 | wb_entrylo1 | wb_pagemask | wb_index, 0);
        n_done = 0;
        repeat (4) begin tick(); if (done) n_done++; end
        chk("rst_mid_stray_done", 32'(n_done), 0);
        do_op(TLB_OP_TLBR, 32'd7, 0, 0, 0, 0);
        chk("rst_lost_write_hi", wb_entryhi, 0);
        check_read("rst_lost_write", 7);
        do_op(TLB_OP_TLBR, 32'd5, 0, 0, 0, 0);
        chk("rst_cleared_lo0", wb_entrylo0, 0);
        check_read("rst_cleared", 5);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
